// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - byte-serial add/subtract over one shared 8-bit lookahead adder

module cladder8 (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);
   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;

   always_comb begin
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < 8; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      s  = p ^ c[7:0];
      co = c[8];
   end
endmodule

module multibyte_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   input  logic                cin,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] sum,
   output logic                cout,
   output logic                ovf,
   output logic                zero
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-9:0]   acc;
   logic [W-1:0]   sum_q;
   logic [W-1:0]   sum_fin;
   logic           carry;
   logic [IW-1:0]  idx;
   logic           cout_q;
   logic           ovf_q;
   logic           zero_q;
   logic [7:0]     s8;
   logic           co8;
   logic           last;

   // operands shift right so the adder always sees the current byte in bits [7:0]
   cladder8 u_add (
      .x  (a_sh[7:0]),
      .y  (b_sh[7:0]),
      .ci (carry),
      .s  (s8),
      .co (co8)
   );

   assign last    = (idx == IW'(NBYTES - 1));
   assign sum_fin = {s8, acc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub | cin;
                  idx   <= '0;
                  acc   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 8;
               b_sh  <= b_sh >> 8;
               acc   <= sum_fin[W-1:8];
               carry <= co8;
               if (last) begin
                  // at the final byte a_sh[7]/b_sh[7] are the operand sign bits
                  sum_q  <= sum_fin;
                  cout_q <= co8;
                  ovf_q  <= (a_sh[7] == b_sh[7]) && (s8[7] != a_sh[7]);
                  zero_q <= (sum_fin == '0);
                  idx    <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - scoreboard bench for multibyte_add_seq

module tb_multibyte_add_seq;
   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cycle = 0;
   bit   hold = 1'b0;
   bit   ov_prev = 1'b0;

   multibyte_add_seq #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cycle);
      end
   endtask

   // reference: whole-word arithmetic straight from the add/subtract rules
   function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic xcin, input logic xsub);
      exp_t       e;
      logic [W-1:0] bp;
      logic [W:0]   full;
      bp      = xsub ? ~xb : xb;
      full    = {1'b0, xa} + {1'b0, bp} + ((xsub ? 1'b1 : xcin) ? (W+1)'(1) : (W+1)'(0));
      e.sum   = full[W-1:0];
      e.cout  = full[W];
      e.ovf   = (xa[W-1] == bp[W-1]) && (e.sum[W-1] != xa[W-1]);
      e.zero  = (e.sum == '0);
      e.acc   = 0;
      return e;
   endfunction

   // called at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xcin, input logic xsub, input bit push);
      exp_t e;
      int   n;
      a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      e     = model(xa, xb, xcin, xsub);
      e.acc = cycle;
      if (push) exp_q.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         n++;
         @(posedge clk); #1;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid) begin
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               if (!ov_prev) chk("latency", 64'(cycle - exp_q[0].acc), 64'(NBYTES));
               chk("sum",  64'(sum),  64'(exp_q[0].sum));
               chk("cout", 64'(cout), 64'(exp_q[0].cout));
               chk("ovf",  64'(ovf),  64'(exp_q[0].ovf));
               chk("zero", 64'(zero), 64'(exp_q[0].zero));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         ov_prev = out_valid;
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum",       64'(sum),       64'd0);
      chk("rst_flags",     64'({cout, ovf, zero}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
      issue(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
      drain();

      // stall in DONE while a competing command is offered
      hold = 1'b1;
      issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
      chk("stall_reached_done", 64'(out_valid), 64'd1);
      repeat (3) @(negedge clk);
      chk("stall_queue", 64'(exp_q.size()), 64'd1);
      hold = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1);
      drain();

      // reset in the middle of a run: that transaction must vanish
      hold = 1'b1;
      @(posedge clk); #1;
      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
      chk("mid_rst_sum",       64'(sum),       64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      hold = 1'b0;
      issue(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1);
      chk("first_edge_accept", 64'(exp_q[0].acc), 64'(cycle));

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(7))
            0: ra = '1;
            1: rb = '0;
            2: ra = {1'b1, {(W-1){1'b0}}};
            3: rb = ra;
            default: ;
         endcase
         issue(ra, rb, 1'($urandom), 1'($urandom), 1'b1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
